memc3_calib_monitor: RTL and testbench
======================================

Name: memc3_calib_monitor

Overview:
- Consumer end of the memc3 infrastructure clock/reset outputs.
- Watches PLL lock and MCB calibration completion, then releases a synchronous user-side reset and a ready flag.
- Detects lock loss, calibration drop and timeouts, and requests an infrastructure reset with bounded retries.
- Sits between memc3_infrastructure/MCB and the user-port logic in the clk0 domain.

Parameters:
- LOCK_TIMEOUT, 65536: clk0 cycles allowed in WAIT_LOCK before a retry.
- CALIB_TIMEOUT, 1048576: clk0 cycles allowed in WAIT_CALIB before a retry.
- SETTLE_CYCLES, 256: cycles that lock and calib_done must stay high before ready (minimum 1).
- MAX_RETRIES, 3: number of retries before the block enters FAIL (0 means fail on the first fault).
- RETRY_PULSE, 16: width of mcb_rst_req in cycles (minimum 1).

Ports:
- clk0  in  1  user clock from the infrastructure.
- async_rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clk0.
- calib_done  in  1  MCB calibration done, asynchronous to clk0.
- clear_fail  in  1  single-cycle pulse; exits FAIL.
- user_rst  out  1  active-high reset for user logic, synchronous to clk0.
- ready  out  1  high only in READY.
- mcb_rst_req  out  1  reset request to the infrastructure.
- fail  out  1  sticky failure flag.
- retry_cnt  out  4  retries used (saturating; MAX_RETRIES must be ≤ 15).
- state_dbg  out  3  encoded state.
- lock_loss_cnt  out  8  optional-feature counter.
- fail_cause  out  2  optional-feature cause code.

Behaviour:
- Reset values while async_rst is high: state WAIT_LOCK, user_rst=1, ready=0, mcb_rst_req=0, fail=0, retry_cnt=0, cycle counter=0, sync flops=0.
- pll_lock and calib_done each pass through a 2-flop synchronizer; lk and cd below are the synchronized values. Input-to-decision latency is 2 cycles.
- One shared cycle counter; width is $clog2 of the largest timeout parameter plus 1. It clears on every state change.
- State encoding: WAIT_LOCK=0, WAIT_CALIB=1, SETTLE=2, READY=3, RETRY=4, FAIL=5.
- WAIT_LOCK:
  - lk=1 -> WAIT_CALIB.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1 -> RETRY, cause=1 (lock timeout).
- WAIT_CALIB:
  - lk=0 -> RETRY, cause=2 (lock loss).
  - Else cd=1 -> SETTLE.
  - Else, when the counter reaches CALIB_TIMEOUT-1 -> RETRY, cause=3 (calib timeout).
- SETTLE:
  - lk=0 or cd=0 -> RETRY, cause 2 or 3; lock loss has priority.
  - Counter reaches SETTLE_CYCLES-1 -> READY.
- READY:
  - ready=1 and user_rst=0, both registered and changing in the cycle READY is entered.
  - lk=0 or cd=0 -> RETRY. ready drops and user_rst asserts on the next clock edge, with no glitch.
- RETRY:
  - On entry, if retry_cnt == MAX_RETRIES -> FAIL immediately, with no mcb_rst_req pulse.
  - Otherwise mcb_rst_req=1 for exactly RETRY_PULSE cycles. retry_cnt increments on entry. Then -> WAIT_LOCK.
- FAIL: fail=1, user_rst=1, ready=0. Held until async_rst, or until clear_fail=1, which zeroes retry_cnt and fail and goes to WAIT_LOCK.
- clear_fail is ignored in every state other than FAIL.
- user_rst=1 in every state except READY.
- Simultaneous events: lock loss beats calib drop, and both beat timeout. A timeout on the same cycle as lk rising still takes the lk=1 transition.
- retry_cnt is cleared only by reset or clear_fail; reaching READY does not clear it.
- async_rst mid-operation: every output returns to its reset value immediately, with no mcb_rst_req pulse.

Optional Feature:
- Macro MEMC3_CALIB_STATUS_EN.
- Defined:
  - lock_loss_cnt is an 8-bit saturating count (sticks at 255) of lk falling edges seen in WAIT_CALIB, SETTLE or READY.
  - fail_cause holds the cause code of the most recent RETRY entry (0 means none yet).
  - Both are cleared by async_rst; clear_fail does not clear them.
- Not defined: both ports tied to 0 and no registers are inferred.

Test Plan (bench params LOCK_TIMEOUT=64, CALIB_TIMEOUT=128, SETTLE_CYCLES=16, MAX_RETRIES=2, RETRY_PULSE=8):
- Normal bring-up: release reset, pll_lock=1 at cycle 10, calib_done=1 at cycle 40 -> ready=1 and user_rst=0 at cycle 40+2+16±1; mcb_rst_req never high.
- Lock timeout: pll_lock held 0 -> mcb_rst_req high for exactly 8 cycles starting at cycle 64, retry_cnt=1; a second pulse follows 64 cycles later, retry_cnt=2; then fail=1, no third pulse, user_rst stays 1.
- Lock loss in READY: after ready, drop pll_lock -> ready falls 3 cycles later (2 sync + 1), 8-cycle mcb_rst_req pulse, retry_cnt increments; with the macro, lock_loss_cnt=1 and fail_cause=2.
- Simultaneous drop: in SETTLE, drop pll_lock and calib_done on the same cycle -> with the macro, fail_cause=2 (lock priority).
- FAIL recovery: in FAIL, pulse clear_fail -> fail=0, retry_cnt=0, state_dbg=0; a normal bring-up then reaches ready.
- Reset mid-retry: assert async_rst during the 4th cycle of the mcb_rst_req pulse -> mcb_rst_req=0 and retry_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/memc3_calib_monitor.sv
// Bring-up monitor for the memc3 clk0 domain: waits for PLL lock and MCB calibration, releases user reset and
// retries the infrastructure on faults. Optional status counters are enabled with `define MEMC3_CALIB_STATUS_EN.
module memc3_calib_monitor #(
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int CALIB_TIMEOUT = 1048576,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int RETRY_PULSE   = 16
) (
    input  logic       clk0,
    input  logic       async_rst,
    input  logic       pll_lock,
    input  logic       calib_done,
    input  logic       clear_fail,
    output logic       user_rst,
    output logic       ready,
    output logic       mcb_rst_req,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_dbg,
    output logic [7:0] lock_loss_cnt,
    output logic [1:0] fail_cause
);

    localparam int MAX_TIMEOUT = (LOCK_TIMEOUT > CALIB_TIMEOUT) ? LOCK_TIMEOUT : CALIB_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RETRY_PULSE - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_WAIT_CALIB = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_READY      = 3'd3,
        ST_RETRY      = 3'd4,
        ST_FAIL       = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             fault;
    logic [CNT_W-1:0] cycle_cnt;
    logic             lk_p0;
    logic             lk_p1;
    logic             cd_p0;
    logic             cd_p1;
    logic             lk;
    logic             cd;

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk0 or posedge async_rst) begin
        if (async_rst) begin
            lk_p0 <= 1'b0;
            lk_p1 <= 1'b0;
            cd_p0 <= 1'b0;
            cd_p1 <= 1'b0;
        end else begin
            lk_p0 <= pll_lock;
            lk_p1 <= lk_p0;
            cd_p0 <= calib_done;
            cd_p1 <= cd_p0;
        end
    end

    assign lk = lk_p1;
    assign cd = cd_p1;

    always_ff @(posedge clk0 or posedge async_rst) begin
        if (async_rst) begin
            state <= ST_WAIT_LOCK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fault      = 1'b0;
        case (state)
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_next = ST_WAIT_CALIB;
                end else if (cycle_cnt == LOCK_LAST) begin
                    fault = 1'b1;
                end
            end
            ST_WAIT_CALIB: begin
                if (!lk) begin
                    fault = 1'b1;
                end else if (cd) begin
                    state_next = ST_SETTLE;
                end else if (cycle_cnt == CALIB_LAST) begin
                    fault = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lk || !cd) begin
                    fault = 1'b1;
                end else if (cycle_cnt == SETTLE_LAST) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (!lk || !cd) begin
                    fault = 1'b1;
                end
            end
            ST_RETRY: begin
                if (cycle_cnt == PULSE_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_FAIL: begin
                if (clear_fail) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
            end
        endcase
        // An exhausted retry budget skips the reset pulse and goes straight to FAIL
        if (fault) begin
            state_next = (retry_cnt == RETRY_LIMIT) ? ST_FAIL : ST_RETRY;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk0 or posedge async_rst) begin
        if (async_rst) begin
            cycle_cnt   <= '0;
            retry_cnt   <= 4'd0;
            user_rst    <= 1'b1;
            ready       <= 1'b0;
            mcb_rst_req <= 1'b0;
            fail        <= 1'b0;
        end else begin
            cycle_cnt   <= (state_next != state) ? '0 : cycle_cnt + 1'b1;
            user_rst    <= (state_next != ST_READY);
            ready       <= (state_next == ST_READY);
            mcb_rst_req <= (state_next == ST_RETRY);
            fail        <= (state_next == ST_FAIL);
            if (state == ST_FAIL && clear_fail) begin
                retry_cnt <= 4'd0;
            end else if (state_next == ST_RETRY && state != ST_RETRY && retry_cnt != 4'hF) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
        end
    end

    assign state_dbg = state;

`ifdef MEMC3_CALIB_STATUS_EN
    logic       lk_prev;
    logic [7:0] loss_cnt;
    logic [1:0] cause;

    // Any fault outside WAIT_LOCK is a lock loss if lk is low, otherwise a calibration fault
    always_ff @(posedge clk0 or posedge async_rst) begin
        if (async_rst) begin
            lk_prev  <= 1'b0;
            loss_cnt <= 8'd0;
            cause    <= 2'd0;
        end else begin
            lk_prev <= lk;
            if ((state == ST_WAIT_CALIB || state == ST_SETTLE || state == ST_READY) &&
                lk_prev && !lk && loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
            if (fault) begin
                cause <= (state == ST_WAIT_LOCK) ? 2'd1 : (lk ? 2'd3 : 2'd2);
            end
        end
    end

    assign lock_loss_cnt = loss_cnt;
    assign fail_cause    = cause;
`else
    assign lock_loss_cnt = 8'd0;
    assign fail_cause    = 2'd0;
`endif

endmodule

// File: tb/tb_memc3_calib_monitor.sv
// Scoreboard bench for memc3_calib_monitor: a phase-timeline model predicts every output change from the
// per-cycle input plan; a monitor pops and compares whenever ready/mcb_rst_req/fail change.
module tb_memc3_calib_monitor;

    localparam int LT  = 64;
    localparam int CT  = 128;
    localparam int STL = 16;
    localparam int MR  = 2;
    localparam int RP  = 8;
    localparam int AN  = 560;

    localparam int P_LOCK  = 0;
    localparam int P_CAL   = 1;
    localparam int P_SET   = 2;
    localparam int P_RDY   = 3;
    localparam int P_RETRY = 4;
    localparam int P_FAIL  = 5;

    logic       clk0 = 1'b0;
    logic       async_rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       calib_done = 1'b0;
    logic       clear_fail = 1'b0;
    logic       user_rst;
    logic       ready;
    logic       mcb_rst_req;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_dbg;
    logic [7:0] lock_loss_cnt;
    logic [1:0] fail_cause;

    always #5 clk0 = ~clk0;

    memc3_calib_monitor #(
        .LOCK_TIMEOUT (LT),
        .CALIB_TIMEOUT(CT),
        .SETTLE_CYCLES(STL),
        .MAX_RETRIES  (MR),
        .RETRY_PULSE  (RP)
    ) dut (
        .clk0         (clk0),
        .async_rst    (async_rst),
        .pll_lock     (pll_lock),
        .calib_done   (calib_done),
        .clear_fail   (clear_fail),
        .user_rst     (user_rst),
        .ready        (ready),
        .mcb_rst_req  (mcb_rst_req),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .state_dbg    (state_dbg),
        .lock_loss_cnt(lock_loss_cnt),
        .fail_cause   (fail_cause)
    );

    typedef struct {
        int   at;
        logic rdy;
        logic mcb;
        logic fl;
        int   retry;
        int   st;
        int   cause;
        int   llc;
    } snap_t;

    snap_t exp_q[$];
    int    pulse_q[$];
    int    ready_rise_at;
    int    ready_fall_at;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    // stim[0]=pll_lock, stim[1]=calib_done, stim[2]=clear_fail; entry e is driven just after edge e
    bit    stim [0:2][0:AN-1];

    int m_s, m_ph, m_r, m_cause, m_llc, m_h;

    always @(posedge clk0) cyc <= async_rst ? 0 : cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill(input int sig, input int lo, input int hi, input bit v);
        for (int i = lo; i <= hi && i < AN; i++) stim[sig][i] = v;
    endtask

    task automatic clear_stim();
        for (int s = 0; s < 3; s++) fill(s, 0, AN - 1, 1'b0);
    endtask

    // Values the monitor acts on at edge k: two sync stages for the status inputs, none for clear_fail
    function automatic bit lk_at(input int k);
        return (k >= 3) ? stim[0][k-3] : 1'b0;
    endfunction

    function automatic bit cd_at(input int k);
        return (k >= 3) ? stim[1][k-3] : 1'b0;
    endfunction

    function automatic bit cf_at(input int k);
        return (k >= 1) ? stim[2][k-1] : 1'b0;
    endfunction

    task automatic emit(input int at, input bit rdy, input bit mcb, input bit fl, input int st);
        snap_t x;
        if (at <= m_h) begin
            x.at = at; x.rdy = rdy; x.mcb = mcb; x.fl = fl; x.st = st;
            x.retry = m_r; x.cause = m_cause; x.llc = m_llc;
            exp_q.push_back(x);
        end
    endtask

    task automatic do_fault(input int f, input int c);
        m_cause = c;
        if (c == 2 && m_llc < 255) m_llc++;
        m_s = f;
        if (m_r == MR) begin
            m_ph = P_FAIL;
            emit(f, 1'b0, 1'b0, 1'b1, 5);
        end else begin
            m_r++;
            m_ph = P_RETRY;
            emit(f, 1'b0, 1'b1, 1'b0, 4);
        end
    endtask

    // Walks the bring-up phases as time intervals and records every visible output change up to edge h
    task automatic build_model(input int h);
        int k;
        exp_q.delete();
        m_h = h; m_s = 0; m_ph = P_LOCK; m_r = 0; m_cause = 0; m_llc = 0;
        while (m_s <= m_h) begin
            case (m_ph)
                P_LOCK: begin
                    k = m_s + 1;
                    while (k < m_s + LT && !lk_at(k)) k++;
                    if (lk_at(k)) begin m_ph = P_CAL; m_s = k; end
                    else do_fault(k, 1);
                end
                P_CAL: begin
                    k = m_s + 1;
                    while (k < m_s + CT && lk_at(k) && !cd_at(k)) k++;
                    if (!lk_at(k)) do_fault(k, 2);
                    else if (cd_at(k)) begin m_ph = P_SET; m_s = k; end
                    else do_fault(k, 3);
                end
                P_SET: begin
                    k = m_s + 1;
                    while (k < m_s + STL && lk_at(k) && cd_at(k)) k++;
                    if (!lk_at(k)) do_fault(k, 2);
                    else if (!cd_at(k)) do_fault(k, 3);
                    else begin m_ph = P_RDY; m_s = k; emit(k, 1'b1, 1'b0, 1'b0, 3); end
                end
                P_RDY: begin
                    k = m_s + 1;
                    while (k <= m_h && lk_at(k) && cd_at(k)) k++;
                    if (k > m_h) m_s = k;
                    else if (!lk_at(k)) do_fault(k, 2);
                    else do_fault(k, 3);
                end
                P_RETRY: begin
                    m_s = m_s + RP;
                    m_ph = P_LOCK;
                    emit(m_s, 1'b0, 1'b0, 1'b0, 0);
                end
                default: begin
                    k = m_s + 1;
                    while (k <= m_h && !cf_at(k)) k++;
                    m_s = k;
                    if (k <= m_h) begin
                        m_r = 0;
                        m_ph = P_LOCK;
                        emit(k, 1'b0, 1'b0, 1'b0, 0);
                    end
                end
            endcase
        end
    endtask

    task automatic check_reset_vals();
        check("rst_user_rst", user_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_mcb_rst_req", mcb_rst_req, 0);
        check("rst_fail", fail, 0);
        check("rst_retry_cnt", retry_cnt, 0);
        check("rst_state_dbg", state_dbg, 0);
        check("rst_lock_loss_cnt", lock_loss_cnt, 0);
        check("rst_fail_cause", fail_cause, 0);
    endtask

    // Runs one plan from reset release through edge h, then asserts async_rst mid-cycle
    task automatic run(input int h, input bit pulse_at_end);
        pulse_q.delete();
        ready_rise_at = -1;
        ready_fall_at = -1;
        build_model(h);
        pll_lock = stim[0][0]; calib_done = stim[1][0]; clear_fail = stim[2][0];
        @(negedge clk0);
        async_rst = 1'b0;
        for (int e = 1; e <= h; e++) begin
            @(posedge clk0);
            #1;
            pll_lock = stim[0][e]; calib_done = stim[1][e]; clear_fail = stim[2][e];
        end
        #2;
        check("pending_events", exp_q.size(), 0);
        if (pulse_at_end) check("pulse_high_before_reset", mcb_rst_req, 1);
        async_rst = 1'b1;
        pll_lock = 1'b0; calib_done = 1'b0; clear_fail = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        repeat (2) @(posedge clk0);
    endtask

    initial begin : monitor
        logic [2:0] prev;
        logic [2:0] cur;
        snap_t      x;
        prev = 3'b000;
        forever begin
            @(posedge clk0);
            #2;
            cur = {ready, mcb_rst_req, fail};
            if (async_rst) begin
                prev = 3'b000;
            end else if (cur != prev) begin
                if (cur[1] && !prev[1]) pulse_q.push_back(cyc);
                if (cur[2] && !prev[2]) ready_rise_at = cyc;
                if (!cur[2] && prev[2]) ready_fall_at = cyc;
                prev = cur;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_change: cycle %0d ready=%0b mcb_rst_req=%0b fail=%0b, no change expected",
                             cyc, ready, mcb_rst_req, fail);
                end else begin
                    x = exp_q.pop_front();
                    check("event_cycle", cyc, x.at);
                    check("ready", ready, x.rdy);
                    check("mcb_rst_req", mcb_rst_req, x.mcb);
                    check("fail", fail, x.fl);
                    check("user_rst", user_rst, !x.rdy);
                    check("retry_cnt", retry_cnt, x.retry);
                    check("state_dbg", state_dbg, x.st);
`ifdef MEMC3_CALIB_STATUS_EN
                    check("lock_loss_cnt", lock_loss_cnt, x.llc);
                    check("fail_cause", fail_cause, x.cause);
`else
                    check("lock_loss_cnt_tied", lock_loss_cnt, 0);
                    check("fail_cause_tied", fail_cause, 0);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int l, c, d, w, kind;
        repeat (3) @(posedge clk0);
        #1;
        check_reset_vals();

        // Normal bring-up
        clear_stim();
        fill(0, 10, AN - 1, 1'b1);
        fill(1, 40, AN - 1, 1'b1);
        run(80, 1'b0);
        check("bringup_ready_cycle", ready_rise_at, 59);
        check("bringup_pulses", pulse_q.size(), 0);

        // Lock timeouts into FAIL, clear_fail, then a late bring-up
        clear_stim();
        fill(0, 230, AN - 1, 1'b1);
        fill(1, 240, AN - 1, 1'b1);
        stim[2][215] = 1'b1;
        run(300, 1'b0);
        check("timeout_pulses", pulse_q.size(), 2);
        if (pulse_q.size() >= 2) begin
            check("timeout_pulse1_start", pulse_q[0], 64);
            check("timeout_pulse2_start", pulse_q[1], 136);
        end
        check("recovery_ready_cycle", ready_rise_at, 259);

        // Lock loss while READY
        clear_stim();
        fill(0, 5, AN - 1, 1'b1);
        fill(1, 20, AN - 1, 1'b1);
        fill(0, 60, 69, 1'b0);
        run(100, 1'b0);
        check("lockloss_ready_fall", ready_fall_at, 63);
        check("lockloss_pulses", pulse_q.size(), 1);
        check("lockloss_reready", ready_rise_at, 90);

        // Both inputs drop together during SETTLE
        clear_stim();
        fill(0, 5, AN - 1, 1'b1);
        fill(1, 20, AN - 1, 1'b1);
        fill(0, 28, 33, 1'b0);
        fill(1, 28, 33, 1'b0);
        run(100, 1'b0);

        // Reset during the 4th cycle of the first retry pulse
        clear_stim();
        run(67, 1'b1);

        for (int i = 0; i < 14; i++) begin
            clear_stim();
            l = $urandom_range(0, 150);
            c = l + $urandom_range(0, 180);
            fill(0, l, AN - 1, 1'b1);
            fill(1, c, AN - 1, 1'b1);
            if ($urandom_range(0, 3) != 0) begin
                d = $urandom_range(50, 300);
                w = $urandom_range(1, 40);
                kind = $urandom_range(0, 2);
                if (kind != 1) fill(0, d, d + w - 1, 1'b0);
                if (kind != 0) fill(1, d, d + w - 1, 1'b0);
            end
            for (int j = 0; j < 3; j++) stim[2][$urandom_range(1, 390)] = 1'b1;
            run(400, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
